mux6_rr_scheduler: RTL

- Round-robin scheduler that time-shares the 6-to-1 bit multiplexer datapath among six requesters.
- Each requester raises a request bit. The block grants one requester at a time for a bounded number of cycles and drives the 3-bit mux select from the grant.
- It exposes the selected data bit plus grant status.
- Sits between board-level request sources (SW/KEY) and the mux datapath; top-level wrapper maps outputs to LEDR.

---
 rtl/mux6_rr_scheduler_pkg.sv | 28 ++
 rtl/mux6_rr_scheduler_mux6.sv | 19 +
 rtl/mux6_rr_scheduler_rr_pick6.sv | 27 ++
 rtl/mux6_rr_scheduler.sv | 108 ++++++++++
 4 files changed

// File: rtl/mux6_rr_scheduler_pkg.sv
// mux6_rr_scheduler shared definitions.
// Requester count, select codes, FSM encodings and ring arithmetic.
package mux6_rr_scheduler_pkg;

    localparam int NUM_REQ = 6;
    localparam int SEL_W   = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Position 'off' steps after 'base' on the six-entry ring.
    function automatic logic [SEL_W-1:0] rr_wrap(
        input logic [SEL_W-1:0] base,
        input logic [SEL_W-1:0] off
    );
        logic [SEL_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'd12) begin
            s = s - 4'd12;
        end else if (s >= 4'd6) begin
            s = s - 4'd6;
        end
        return s[SEL_W-1:0];
    endfunction

endpackage

// File: rtl/mux6_rr_scheduler_mux6.sv
// Six-to-one single-bit datapath mux.
// Codes 6 and 7 produce a constant zero.
module mux6
    import mux6_rr_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_data,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_out
);

    // Route the selected data bit; unused codes read as zero.
    always_comb begin
        o_out = 1'b0;
        if (i_sel < SEL_W'(NUM_REQ)) begin
            o_out = i_data[i_sel];
        end
    end

endmodule

// File: rtl/mux6_rr_scheduler_rr_pick6.sv
// Combinational round-robin pick over six request lines.
// Search starts one past the pointer; the pointer's own slot is checked last.
module rr_pick6
    import mux6_rr_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_pick,
    output logic               o_any_req
);

    logic [SEL_W-1:0] w_idx;

    // Walk the ring from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_pick    = i_ptr;
        w_idx     = '0;
        o_any_req = |i_req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = rr_wrap(i_ptr, SEL_W'(k));
            if (i_req[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux6_rr_scheduler.sv
// Round-robin scheduler sharing the 6:1 mux among six requesters.
// Each grant lasts at most HOLD_CYCLES enabled cycles.
module mux6_rr_scheduler
    import mux6_rr_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = 4
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_data,
    output logic [SEL_W-1:0]   o_mux_select,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_out,
    output logic               o_busy
);

    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [SEL_W-1:0]   w_pick;
    logic               w_any;
    logic               w_owner_req;
    logic               w_release;
    logic               w_load;
    logic               w_to_idle;
    logic [NUM_REQ-1:0] w_onehot;

    rr_pick6 u_pick (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_any_req (w_any)
    );

    mux6 u_mux (
        .i_data (i_data),
        .i_sel  (r_sel),
        .o_out  (o_out)
    );

    // Owner still asking is read through the one-hot grant, safe when idle.
    assign w_owner_req = |(i_req & r_grant);
    assign w_release   = (r_cnt == '0) || !w_owner_req;
    assign w_onehot    = NUM_REQ'(1) << w_pick;

    // Decide between loading a new grant, dropping to idle, or holding.
    always_comb begin
        w_load    = 1'b0;
        w_to_idle = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = w_any;
            end
            ST_HOLD: begin
                if (w_release) begin
                    w_load    = w_any;
                    w_to_idle = !w_any;
                end
            end
            default: begin
                w_to_idle = 1'b1;
            end
        endcase
    end

    // Grant, pointer and hold counter advance only on enabled cycles.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= SEL_IDLE;
            r_ptr   <= SEL_W'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_enable) begin
            if (w_load) begin
                r_state <= ST_HOLD;
                r_grant <= w_onehot;
                r_sel   <= w_pick;
                r_ptr   <= w_pick;
                r_cnt   <= HOLD_RELOAD;
                r_busy  <= 1'b1;
            end else if (w_to_idle) begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_sel   <= SEL_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (r_state == ST_HOLD) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_grant      = r_grant;
    assign o_mux_select = r_sel;
    assign o_busy       = r_busy;

endmodule
